priority_decoder_3to8_seq: RTL

PRIORITY_DECODER_3TO8_SEQ -- requirements
Module: priority_decoder_3to8_seq

---
 rtl/priority_decoder_3to8_seq.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/priority_decoder_3to8_seq.sv
// Sequenced 3-to-8 decoder: each accepted code drives a one-hot output for HOLD cycles,
// followed by GAP idle cycles. Define DEC_FIFO_EN to add a 2-entry input FIFO.
module priority_decoder_3to8_seq #(
    parameter int unsigned HOLD = 4,
    parameter int unsigned GAP  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [2:0] in_idx,
    output logic       in_ready,
    output logic [7:0] o,
    output logic       busy,
    output logic       done
);

    localparam logic [7:0] HoldM1 = 8'(HOLD - 1);
    localparam logic [7:0] GapM1  = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

    typedef enum logic [1:0] {
        StIdle,
        StActive,
        StGap
    } state_e;

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic [7:0] o_q, o_d;
    logic       live_q;
    logic       accept;
    logic       have_code;
    logic [2:0] load_idx;
    logic       load;

    // Holds in_ready low until the first edge after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= 1'b0;
        end else begin
            live_q <= 1'b1;
        end
    end

`ifdef DEC_FIFO_EN
    logic [2:0] mem_q [2];
    logic       wr_ptr_q, rd_ptr_q;
    logic [1:0] count_q;
    logic       full, empty;

    assign full      = (count_q == 2'd2);
    assign empty     = (count_q == 2'd0);
    assign in_ready  = live_q & ~full;
    assign accept    = in_valid & in_ready;
    assign have_code = ~empty;
    assign load_idx  = mem_q[rd_ptr_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= 3'd0;
            mem_q[1] <= 3'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (accept) begin
                mem_q[wr_ptr_q] <= in_idx;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (load) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({accept, load})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end
`else
    assign in_ready  = live_q & (state_q == StIdle);
    assign accept    = in_valid & in_ready;
    assign have_code = accept;
    assign load_idx  = in_idx;
`endif

    // Without the FIFO have_code is only ever true in IDLE, so the end-of-window
    // reload paths below are inert in that build.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        o_d     = o_q;
        load    = 1'b0;
        case (state_q)
            StIdle: begin
                o_d = 8'd0;
                if (have_code) begin
                    load = 1'b1;
                end
            end
            StActive: begin
                if (cnt_q == 8'd0) begin
                    o_d = 8'd0;
                    if (GAP > 0) begin
                        state_d = StGap;
                        cnt_d   = GapM1;
                    end else begin
                        state_d = StIdle;
                        if (have_code) begin
                            load = 1'b1;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            StGap: begin
                o_d = 8'd0;
                if (cnt_q == 8'd0) begin
                    state_d = StIdle;
                    if (have_code) begin
                        load = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = StIdle;
                cnt_d   = 8'd0;
                o_d     = 8'd0;
            end
        endcase
        if (load) begin
            state_d = StActive;
            cnt_d   = HoldM1;
            o_d     = 8'd1 << load_idx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            cnt_q   <= 8'd0;
            o_q     <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            o_q     <= o_d;
        end
    end

    assign o    = o_q;
    assign busy = (state_q != StIdle);
    assign done = (state_q == StActive) && (cnt_q == 8'd0);

endmodule
